// File: rtl/half_sub.sv
// Lane-parallel half subtractor with one register stage.
// Each lane yields D=A^B and Bo=~A&B; borrow summary is OR and popcount.
module half_sub #(
  parameter  int WIDTH = 1,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Bo,
  output logic             bo_any,
  output logic [CNT_W-1:0] bo_count
);

  logic [WIDTH-1:0] d_nxt;
  logic [WIDTH-1:0] bo_nxt;
  logic             any_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Lanes are independent: no borrow ripples between bits.
  always_comb begin
    d_nxt   = A ^ B;
    bo_nxt  = ~A & B;
    any_nxt = |bo_nxt;
    cnt_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt = cnt_nxt + CNT_W'(bo_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      D         <= '0;
      Bo        <= '0;
      bo_any    <= 1'b0;
      bo_count  <= '0;
    end else begin
      out_valid <= in_valid;
      // Results only load on valid, so idle-cycle X on A/B never lands.
      if (in_valid) begin
        D        <= d_nxt;
        Bo       <= bo_nxt;
        bo_any   <= any_nxt;
        bo_count <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_half_sub.sv
// Directed bench for half_sub at WIDTH=1 and WIDTH=8.
// Inputs change on negedge; outputs are sampled on the following negedge.
module tb_half_sub;

  logic       clk;
  logic       rst_n;

  logic       v1;
  logic [0:0] a1, b1;
  logic       ov1;
  logic [0:0] d1, bo1;
  logic       any1;
  logic [0:0] cnt1;

  logic       v8;
  logic [7:0] a8, b8;
  logic       ov8;
  logic [7:0] d8, bo8;
  logic       any8;
  logic [3:0] cnt8;

  int checks = 0;
  int errors = 0;

  half_sub #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .A(a1), .B(b1),
    .out_valid(ov1), .D(d1), .Bo(bo1), .bo_any(any1), .bo_count(cnt1)
  );

  half_sub #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .A(a8), .B(b8),
    .out_valid(ov8), .D(d8), .Bo(bo8), .bo_any(any8), .bo_count(cnt8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {out_valid, D, Bo, bo_any, bo_count}
  function automatic logic [4:0] obs1();
    return {ov1, d1, bo1, any1, cnt1};
  endfunction

  function automatic logic [21:0] obs8();
    return {ov8, d8, bo8, any8, cnt8};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (obs1() !== 5'b0) begin
      errors++;
      $display("FAIL reset_w1 got %b want %b", obs1(), 5'b0);
    end
    checks++;
    if (obs8() !== 22'h0) begin
      errors++;
      $display("FAIL reset_w8 got %h want %h", obs8(), 22'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ov1 !== 1'b0 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL release_idle got %b%b want 00", ov1, ov8);
    end
  endtask

  task automatic test_zero();
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
    @(negedge clk);
    checks++;
    if (obs1() !== 5'b1_0_0_0_0) begin
      errors++;
      $display("FAIL zero_w1 got %b want %b", obs1(), 5'b10000);
    end
  endtask

  // Back-to-back sweep: each negedge checks the previous vector.
  task automatic test_sweep();
    logic [1:0] ab [3] = '{2'b01, 2'b10, 2'b11};
    logic [4:0] ex [3] = '{5'b1_1_1_1_1, 5'b1_1_0_0_0, 5'b1_0_0_0_0};
    for (int i = 0; i < 3; i++) begin
      v1 = 1'b1; a1 = ab[i][1]; b1 = ab[i][0];
      @(negedge clk);
      checks++;
      if (obs1() !== ex[i]) begin
        errors++;
        $display("FAIL sweep_w1[%0d] got %b want %b", i, obs1(), ex[i]);
      end
    end
    v1 = 1'b0;
    @(negedge clk);
    checks++;
    if (obs1() !== 5'b0_0_0_0_0) begin
      errors++;
      $display("FAIL sweep_idle_w1 got %b want %b", obs1(), 5'b0);
    end
  endtask

  task automatic test_wide();
    logic [7:0]  av [3] = '{8'h0F, 8'h3C, 8'hA5};
    logic [7:0]  bv [3] = '{8'h3C, 8'h0F, 8'h5A};
    logic [21:0] ex [3] = '{
      {1'b1, 8'h33, 8'h30, 1'b1, 4'd2},
      {1'b1, 8'h33, 8'h03, 1'b1, 4'd2},
      {1'b1, 8'hFF, 8'h5A, 1'b1, 4'd4}
    };
    for (int i = 0; i < 3; i++) begin
      v8 = 1'b1; a8 = av[i]; b8 = bv[i];
      @(negedge clk);
      checks++;
      if (obs8() !== ex[i]) begin
        errors++;
        $display("FAIL wide_w8[%0d] got %h want %h", i, obs8(), ex[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [21:0] ex = {1'b0, 8'hFF, 8'h5A, 1'b1, 4'd4};
    v8 = 1'b0; a8 = 8'hxx; b8 = 8'hzz;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs8() !== ex) begin
        errors++;
        $display("FAIL hold_w8[%0d] got %h want %h", i, obs8(), ex);
      end
    end
  endtask

  task automatic test_boundary();
    logic [21:0] ex_a = {1'b1, 8'h00, 8'h00, 1'b0, 4'd0};
    logic [21:0] ex_b = {1'b1, 8'hFF, 8'hFF, 1'b1, 4'd8};
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    checks++;
    if (obs8() !== ex_a) begin
      errors++;
      $display("FAIL all_ones_w8 got %h want %h", obs8(), ex_a);
    end
    a8 = 8'h00; b8 = 8'hFF;
    @(negedge clk);
    checks++;
    if (obs8() !== ex_b) begin
      errors++;
      $display("FAIL full_borrow_w8 got %h want %h", obs8(), ex_b);
    end
  endtask

  task automatic test_async_reset();
    logic [21:0] ex_new = {1'b1, 8'h01, 8'h00, 1'b0, 4'd0};
    // Still valid from the previous task, so out_valid is high here.
    v1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (ov8 !== 1'b1 || ov1 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid got %b%b want 11", ov1, ov8);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs8() !== 22'h0) begin
      errors++;
      $display("FAIL async_clear_w8 got %h want %h", obs8(), 22'h0);
    end
    checks++;
    if (obs1() !== 5'b0) begin
      errors++;
      $display("FAIL async_clear_w1 got %b want %b", obs1(), 5'b0);
    end
    @(negedge clk);
    v1 = 1'b0; v8 = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (obs8() !== 22'h0 || obs1() !== 5'b0) begin
        errors++;
        $display("FAIL post_reset_idle got %h/%b want 0/0", obs8(), obs1());
      end
    end
    v8 = 1'b1; a8 = 8'h81; b8 = 8'h80;
    @(negedge clk);
    checks++;
    if (obs8() !== ex_new) begin
      errors++;
      $display("FAIL post_reset_new_w8 got %h want %h", obs8(), ex_new);
    end
    v8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_sweep();
    test_wide();
    test_hold();
    test_boundary();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
